// File: rtl/aes_stream_adapter_pkg.sv
// ----------------------------------------------------------------------------
// aes_stream_pkg
// Shared definitions for the AES stream adapter: the FSM state type, the
// word/block geometry and a helper that maps a word slot number onto the bit
// offset of that word inside a 128-bit block (slot 0 is the most significant
// word, bits [127:96]).
// ----------------------------------------------------------------------------
package aes_stream_pkg;

   localparam int WORD_W          = 32;
   localparam int WORDS_PER_BLOCK = 4;
   localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Slot 0 lands in the top word of the block, slot 3 in the bottom word,
   // so the first word of a stream group is always the most significant.
   function automatic int slotLsb(input logic [1:0] idx);
      return (WORDS_PER_BLOCK - 1 - int'(idx)) * WORD_W;
   endfunction

endpackage

// File: rtl/aes_stream_adapter.sv
// ----------------------------------------------------------------------------
// aes_stream_adapter
// Wraps the AES core with a 32-bit valid/ready input stream and a 32-bit
// valid/ready output stream. Key and data words are gathered into 128-bit
// registers, the core is enabled until it reports a result (or a timeout
// expires), and the captured result is streamed back out MSW first.
//
// Ports:
//   AES_clk            clock, rising edge
//   AES_rst_n          asynchronous active-low reset
//   s_valid/s_ready    input word handshake
//   s_data             input word, first word of a group is bits [127:96]
//   s_key              1 = key word, 0 = data word
//   aes_en             enable to the core, high for the whole RUN phase
//   aes_data_in        128-bit plaintext to the core
//   aes_key_in         128-bit key to the core
//   aes_data_out       128-bit result from the core
//   aes_data_out_valid result strobe from the core
//   m_valid/m_ready    output word handshake
//   m_data             output word, MSW first
//   m_last             marks the 4th output word
//   err                one-cycle pulse on timeout or protocol error
// ----------------------------------------------------------------------------
module aes_stream_adapter
   import aes_stream_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TO_W           = 8
) (
   input  logic                AES_clk,
   input  logic                AES_rst_n,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [WORD_W-1:0]   s_data,
   input  logic                s_key,
   output logic                aes_en,
   output logic [BLOCK_W-1:0]  aes_data_in,
   output logic [BLOCK_W-1:0]  aes_key_in,
   input  logic [BLOCK_W-1:0]  aes_data_out,
   input  logic                aes_data_out_valid,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [WORD_W-1:0]   m_data,
   output logic                m_last,
   output logic                err
);

   state_t              r_state;
   state_t              w_nextState;

   logic [1:0]          r_keyCnt;
   logic [1:0]          r_dataCnt;
   logic [1:0]          r_outCnt;
   logic [TO_W-1:0]     r_toCnt;
   logic [BLOCK_W-1:0]  r_key;
   logic [BLOCK_W-1:0]  r_data;
   logic [BLOCK_W-1:0]  r_result;
   logic                r_err;

   logic                w_sHs;
   logic                w_mHs;
   logic                w_keyAccept;
   logic                w_keyReject;
   logic                w_dataWord;
   logic                w_lastData;
   logic                w_capture;
   logic                w_timeout;
   logic                w_lastOut;

   // Handshake and event decode shared by the FSM and the datapath. A key
   // word is only legal at a block boundary (no data words gathered yet);
   // otherwise it is swallowed and flagged. A result strobe that coincides
   // with the final timeout cycle counts as a result, not a timeout.
   always_comb begin
      w_sHs       = s_valid & s_ready;
      w_mHs       = m_valid & m_ready;
      w_keyAccept = w_sHs & s_key & (r_dataCnt == 2'd0);
      w_keyReject = w_sHs & s_key & (r_dataCnt != 2'd0);
      w_dataWord  = w_sHs & ~s_key;
      w_lastData  = w_dataWord & (r_dataCnt == 2'd3);
      w_capture   = (r_state == RUN) & aes_data_out_valid;
      w_timeout   = (r_state == RUN) & ~aes_data_out_valid &
                    (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1));
      w_lastOut   = w_mHs & (r_outCnt == 2'd3);
   end

   // State register. Reset parks the FSM in IDLE so every state-derived
   // output drops the moment reset is asserted.
   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. IDLE only exists to hold s_ready low until the first
   // clock edge after reset release.
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         IDLE:    w_nextState = LOAD;
         LOAD:    if (w_lastData) w_nextState = RUN;
         RUN: begin
            if (w_capture)      w_nextState = DRAIN;
            else if (w_timeout) w_nextState = LOAD;
         end
         DRAIN:   if (w_lastOut) w_nextState = LOAD;
         default: w_nextState = IDLE;
      endcase
   end

   // Output decode. Everything the stream sides see is derived from the
   // registered state and counters, so nothing glitches with the inputs.
   always_comb begin
      s_ready     = (r_state == LOAD);
      aes_en      = (r_state == RUN);
      m_valid     = (r_state == DRAIN);
      m_last      = (r_state == DRAIN) && (r_outCnt == 2'd3);
      m_data      = r_result[slotLsb(r_outCnt) +: WORD_W];
      aes_data_in = r_data;
      aes_key_in  = r_key;
      err         = r_err;
   end

   // Datapath: word packing into the key/data blocks, result capture, the
   // saturating RUN watchdog and the output word pointer. The timeout path
   // keeps the key but throws away the half-used plaintext.
   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         r_keyCnt  <= 2'd0;
         r_dataCnt <= 2'd0;
         r_outCnt  <= 2'd0;
         r_toCnt   <= '0;
         r_key     <= '0;
         r_data    <= '0;
         r_result  <= '0;
         r_err     <= 1'b0;
      end else begin
         r_err <= w_keyReject | w_timeout;

         if (w_keyAccept) begin
            r_key[slotLsb(r_keyCnt) +: WORD_W] <= s_data;
            r_keyCnt <= r_keyCnt + 2'd1;
         end

         if (w_dataWord) begin
            r_data[slotLsb(r_dataCnt) +: WORD_W] <= s_data;
            r_dataCnt <= r_dataCnt + 2'd1;
         end

         if (w_capture) begin
            r_result <= aes_data_out;
            r_toCnt  <= '0;
         end else if (w_timeout) begin
            r_data    <= '0;
            r_keyCnt  <= 2'd0;
            r_dataCnt <= 2'd0;
            r_outCnt  <= 2'd0;
            r_toCnt   <= '0;
         end else if ((r_state == RUN) && (r_toCnt != {TO_W{1'b1}})) begin
            r_toCnt <= r_toCnt + 1'b1;
         end

         if (w_mHs) begin
            r_outCnt <= r_outCnt + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_aes_stream_adapter.sv
// ----------------------------------------------------------------------------
// tb_aes_stream_adapter
// Drives the adapter with directed and randomized blocks. A small model keeps
// the key and plaintext as arrays of words plus word counters, and the core is
// stood in for by the bench itself, answering after a chosen delay (or never).
// ----------------------------------------------------------------------------
module tb_aes_stream_adapter;

   localparam int TIMEOUT = 64;

   logic          AES_clk = 1'b0;
   logic          AES_rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [31:0]   s_data = '0;
   logic          s_key = 1'b0;
   logic          aes_en;
   logic [127:0]  aes_data_in;
   logic [127:0]  aes_key_in;
   logic [127:0]  aes_data_out = '0;
   logic          aes_data_out_valid = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [31:0]   m_data;
   logic          m_last;
   logic          err;

   aes_stream_adapter #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(8)) dut (
      .AES_clk            (AES_clk),
      .AES_rst_n          (AES_rst_n),
      .s_valid            (s_valid),
      .s_ready            (s_ready),
      .s_data             (s_data),
      .s_key              (s_key),
      .aes_en             (aes_en),
      .aes_data_in        (aes_data_in),
      .aes_key_in         (aes_key_in),
      .aes_data_out       (aes_data_out),
      .aes_data_out_valid (aes_data_out_valid),
      .m_valid            (m_valid),
      .m_ready            (m_ready),
      .m_data             (m_data),
      .m_last             (m_last),
      .err                (err)
   );

   always #5 AES_clk = ~AES_clk;

   int            vectors = 0;
   int            miscompares = 0;
   logic [31:0]   mKey[4];
   logic [31:0]   mData[4];
   logic [31:0]   mRes[4];
   int            mKeyCnt;
   int            mDataCnt;

   // Global safety net so a wedged run still ends with a report.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Every comparison funnels through here.
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [127:0] pack(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2, input logic [31:0] w3);
      return {w0, w1, w2, w3};
   endfunction

   task automatic tick();
      @(posedge AES_clk);
      #1;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 4; i++) begin
         mKey[i]  = '0;
         mData[i] = '0;
      end
      mKeyCnt  = 0;
      mDataCnt = 0;
   endtask

   // Offers one word in LOAD and checks what the model says must follow.
   task automatic applyStimulus(input bit isKey, input logic [31:0] w);
      s_valid = 1'b1;
      s_key   = isKey;
      s_data  = w;
      checkOutput("sReadyLoad", s_ready, 1'b1);
      tick();
      s_valid = 1'b0;
      s_key   = 1'b0;
      s_data  = $urandom;
      if (isKey) begin
         if (mDataCnt == 0) begin
            mKey[mKeyCnt] = w;
            mKeyCnt = (mKeyCnt + 1) % 4;
            checkOutput("errKeyOk", err, 1'b0);
         end else begin
            checkOutput("errProto", err, 1'b1);
         end
      end else begin
         mData[mDataCnt] = w;
         mDataCnt++;
         checkOutput("errData", err, 1'b0);
         if (mDataCnt == 4) begin
            mDataCnt = 0;
            checkOutput("aesEnRise", aes_en, 1'b1);
            checkOutput("sReadyRun", s_ready, 1'b0);
         end else begin
            checkOutput("aesEnLoad", aes_en, 1'b0);
         end
      end
      checkOutput("keyReg", aes_key_in, pack(mKey[0], mKey[1], mKey[2], mKey[3]));
      checkOutput("dataReg", aes_data_in, pack(mData[0], mData[1], mData[2], mData[3]));
   endtask

   task automatic sendData(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
      applyStimulus(1'b0, d0);
      applyStimulus(1'b0, d1);
      applyStimulus(1'b0, d2);
      applyStimulus(1'b0, d3);
   endtask

   // Plays the core for one RUN phase. delay < 0 means the core never
   // answers; otherwise the result strobe comes after 'delay' RUN cycles and
   // is held a little into DRAIN with different data to prove single capture.
   task automatic runBlock(input int delay, input int stallWord, input int stallLen);
      int k;
      int cycles;
      int stalled;
      int hold;
      if (delay < 0) begin
         for (int i = 0; i < TIMEOUT; i++) begin
            checkOutput("aesEnWait", aes_en, 1'b1);
            checkOutput("errWait", err, 1'b0);
            tick();
         end
         for (int i = 0; i < 4; i++) mData[i] = '0;
         mKeyCnt  = 0;
         mDataCnt = 0;
         checkOutput("errTimeout", err, 1'b1);
         checkOutput("aesEnTimeout", aes_en, 1'b0);
         checkOutput("sReadyTimeout", s_ready, 1'b1);
         checkOutput("mValidTimeout", m_valid, 1'b0);
         checkOutput("dataCleared", aes_data_in, 128'd0);
         checkOutput("keyKept", aes_key_in, pack(mKey[0], mKey[1], mKey[2], mKey[3]));
         tick();
         checkOutput("errOnePulse", err, 1'b0);
         return;
      end
      for (int i = 0; i < delay; i++) begin
         checkOutput("aesEnHeld", aes_en, 1'b1);
         checkOutput("mValidRun", m_valid, 1'b0);
         tick();
      end
      checkOutput("dataInStable", aes_data_in, pack(mData[0], mData[1], mData[2], mData[3]));
      checkOutput("keyInStable", aes_key_in, pack(mKey[0], mKey[1], mKey[2], mKey[3]));
      aes_data_out       = pack(mRes[0], mRes[1], mRes[2], mRes[3]);
      aes_data_out_valid = 1'b1;
      tick();
      aes_data_out = {$urandom, $urandom, $urandom, $urandom};
      checkOutput("aesEnFall", aes_en, 1'b0);
      checkOutput("mValidRise", m_valid, 1'b1);
      k = 0;
      cycles = 0;
      stalled = 0;
      hold = 2;
      while (k < 4 && cycles < 200) begin
         if (hold > 0) hold--;
         else aes_data_out_valid = 1'b0;
         if (k == stallWord && stalled < stallLen) begin
            m_ready = 1'b0;
            stalled++;
         end else begin
            m_ready = 1'($urandom_range(0, 1));
         end
         checkOutput("mValid", m_valid, 1'b1);
         checkOutput("mData", m_data, mRes[k]);
         checkOutput("mLast", m_last, k == 3);
         checkOutput("sReadyDrain", s_ready, 1'b0);
         tick();
         if (m_ready) k++;
         cycles++;
      end
      m_ready = 1'b0;
      aes_data_out_valid = 1'b0;
      checkOutput("drainDone", k == 4, 1'b1);
      checkOutput("mValidFall", m_valid, 1'b0);
      checkOutput("sReadyBack", s_ready, 1'b1);
   endtask

   initial begin
      int nKey;
      int delay;
      modelReset();
      #2;
      checkOutput("rstSReady", s_ready, 1'b0);
      checkOutput("rstAesEn", aes_en, 1'b0);
      checkOutput("rstMValid", m_valid, 1'b0);
      checkOutput("rstMLast", m_last, 1'b0);
      checkOutput("rstErr", err, 1'b0);
      checkOutput("rstKey", aes_key_in, 128'd0);
      checkOutput("rstData", aes_data_in, 128'd0);
      tick();
      tick();
      checkOutput("rstSReadyHeld", s_ready, 1'b0);
      AES_rst_n = 1'b1;
      tick();
      checkOutput("firstEdgeSReady", s_ready, 1'b1);

      $display("[TB] directed block with key");
      applyStimulus(1'b1, 32'haa2bdb40);
      applyStimulus(1'b1, 32'hbff6a5e8);
      applyStimulus(1'b1, 32'hcaa9ba3e);
      applyStimulus(1'b1, 32'hbc1e2acc);
      sendData(32'h00000023, 32'h0, 32'h0, 32'h0);
      checkOutput("tpKey", aes_key_in, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
      checkOutput("tpData", aes_data_in, 128'h00000023_00000000_00000000_00000000);
      mRes[0] = 32'h01234567; mRes[1] = 32'h89abcdef;
      mRes[2] = 32'hfedcba98; mRes[3] = 32'h76543210;
      runBlock(20, -1, 0);

      $display("[TB] key reuse with output stall");
      sendData(32'ha6f2daeb, 32'h140fa720, 32'h529e75d5, 32'h21cbc681);
      checkOutput("reuseKey", aes_key_in, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
      runBlock(4, 1, 5);

      $display("[TB] core timeout");
      sendData($urandom, $urandom, $urandom, $urandom);
      runBlock(-1, -1, 0);
      for (int i = 0; i < 4; i++) mRes[i] = $urandom;
      sendData($urandom, $urandom, $urandom, $urandom);
      runBlock(3, -1, 0);

      $display("[TB] key word inside a block");
      applyStimulus(1'b0, $urandom);
      applyStimulus(1'b0, $urandom);
      applyStimulus(1'b1, 32'h11111111);
      applyStimulus(1'b0, $urandom);
      applyStimulus(1'b0, $urandom);
      for (int i = 0; i < 4; i++) mRes[i] = $urandom;
      runBlock(7, 3, 2);

      $display("[TB] randomized blocks");
      for (int b = 0; b < 10; b++) begin
         nKey = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0;
         for (int i = 0; i < nKey; i++) applyStimulus(1'b1, $urandom);
         for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, $urandom);
            if (i < 3 && $urandom_range(0, 4) == 0) applyStimulus(1'b1, $urandom);
         end
         for (int i = 0; i < 4; i++) mRes[i] = $urandom;
         delay = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 40);
         runBlock(delay, $urandom_range(0, 3), $urandom_range(0, 4));
      end

      $display("[TB] reset during RUN");
      sendData($urandom, $urandom, $urandom, $urandom);
      tick();
      tick();
      #3;
      AES_rst_n = 1'b0;
      #1;
      checkOutput("midRstAesEn", aes_en, 1'b0);
      checkOutput("midRstSReady", s_ready, 1'b0);
      checkOutput("midRstMValid", m_valid, 1'b0);
      checkOutput("midRstErr", err, 1'b0);
      @(posedge AES_clk);
      @(posedge AES_clk);
      #3;
      AES_rst_n = 1'b1;
      modelReset();
      tick();
      checkOutput("relSReady", s_ready, 1'b1);
      checkOutput("relKey", aes_key_in, 128'd0);
      checkOutput("relAesEn", aes_en, 1'b0);
      checkOutput("relMValid", m_valid, 1'b0);
      sendData($urandom, $urandom, $urandom, $urandom);
      for (int i = 0; i < 4; i++) mRes[i] = $urandom;
      runBlock(2, -1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
